// File: rtl/fp_pkg.sv
// Shared binary32 field widths, constants, op encoding and unpacked-operand type
// used by the add/sub/multiply unit.
package fp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned BIAS   = 127;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W:0]   sig;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
  } fp_unpacked_t;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int unsigned i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  // Saturates to signed infinity on overflow and signed zero on underflow.
  function automatic logic [31:0] pack_fp(input logic sign,
                                          input logic signed [9:0] exp,
                                          input logic [FRAC_W-1:0] frac);
    logic [31:0] r;
    if (exp >= 10'sd255)   r = {sign, POS_INF[30:0]};
    else if (exp <= 10'sd0) r = {sign, 31'd0};
    else                    r = {sign, exp[7:0], frac};
    return r;
  endfunction

endpackage

// File: rtl/fp_extract.sv
// Combinational binary32 unpacker with subnormal flush-to-zero.
module fp_extract
  import fp_pkg::*;
(
  input  logic [31:0]  value,
  output fp_unpacked_t fields
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  assign exp_f  = value[30:23];
  assign frac_f = value[22:0];

  always_comb begin
    fields.sign    = value[31];
    fields.exp     = exp_f;
    fields.sig     = (exp_f != '0) ? {1'b1, frac_f} : '0;
    fields.is_zero = (exp_f == '0);
    fields.is_inf  = (exp_f == '1) && (frac_f == '0);
    fields.is_nan  = (exp_f == '1) && (frac_f != '0);
  end

endmodule

// File: rtl/fp_add_mul_unit.sv
// Binary32 add/subtract/multiply with truncating rounding and a single
// registered output stage.
module fp_add_mul_unit
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        out_valid
);

  fp_unpacked_t ua, ub;
  op_e          op_sel;
  logic         sb_eff;
  logic         a_big;

  fp_extract u_ext_a (.value(A), .fields(ua));
  fp_extract u_ext_b (.value(B), .fields(ub));

  assign op_sel = op_e'(op);
  assign sb_eff = ub.sign ^ (op_sel == OP_SUB);
  assign a_big  = {ua.exp, ua.sig} >= {ub.exp, ub.sig};

  logic              lg_sign, sm_sign;
  logic [EXP_W-1:0]  lg_exp, sm_exp, shift;
  logic [FRAC_W:0]   lg_sig, sm_sig, sm_shifted, dif, norm_dif;
  logic [24:0]       sum;
  logic [4:0]        lz;
  logic signed [9:0] exp_add;
  logic [FRAC_W-1:0] frac_add;
  logic [31:0]       add_core, add_res;

  always_comb begin
    lg_sign    = a_big ? ua.sign : sb_eff;
    sm_sign    = a_big ? sb_eff  : ua.sign;
    lg_exp     = a_big ? ua.exp  : ub.exp;
    sm_exp     = a_big ? ub.exp  : ua.exp;
    lg_sig     = a_big ? ua.sig  : ub.sig;
    sm_sig     = a_big ? ub.sig  : ua.sig;
    shift      = lg_exp - sm_exp;
    sm_shifted = sm_sig >> shift;
    sum        = {1'b0, lg_sig} + {1'b0, sm_shifted};
    dif        = lg_sig - sm_shifted;
    lz         = lzc24(dif);
    norm_dif   = dif << lz;
    exp_add    = $signed({2'b00, lg_exp});
    frac_add   = '0;
    if (lg_sign == sm_sign) begin
      if (sum[24]) begin
        frac_add = sum[23:1];
        exp_add  = $signed({2'b00, lg_exp}) + 10'sd1;
      end else begin
        frac_add = sum[22:0];
      end
    end else begin
      frac_add = norm_dif[22:0];
      exp_add  = $signed({2'b00, lg_exp}) - $signed({5'b00000, lz});
    end
    add_core = pack_fp(lg_sign, exp_add, frac_add);
    if ((lg_sign != sm_sign) && (dif == '0)) add_core = '0;
  end

  always_comb begin
    add_res = add_core;
    if (ua.is_nan || ub.is_nan)                          add_res = QNAN;
    else if (ua.is_inf && ub.is_inf && ua.sign != sb_eff) add_res = QNAN;
    else if (ua.is_inf)                                  add_res = {ua.sign, POS_INF[30:0]};
    else if (ub.is_inf)                                  add_res = {sb_eff, POS_INF[30:0]};
    else if (ua.is_zero && ub.is_zero)                   add_res = (ua.sign == sb_eff) ? {ua.sign, 31'd0} : '0;
    else if (ua.is_zero)                                 add_res = {sb_eff, ub.exp, ub.sig[22:0]};
    else if (ub.is_zero)                                 add_res = {ua.sign, ua.exp, ua.sig[22:0]};
  end

  logic              sx;
  logic [47:0]       prod;
  logic signed [9:0] exp_mul;
  logic [FRAC_W-1:0] frac_mul;
  logic [31:0]       mul_res;

  always_comb begin
    sx       = ua.sign ^ ub.sign;
    prod     = ua.sig * ub.sig;
    exp_mul  = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - 10'sd127;
    frac_mul = prod[45:23];
    if (prod[47]) begin
      frac_mul = prod[46:24];
      exp_mul  = exp_mul + 10'sd1;
    end
    mul_res = pack_fp(sx, exp_mul, frac_mul);
    if (ua.is_nan || ub.is_nan)                                         mul_res = QNAN;
    else if ((ua.is_inf && ub.is_zero) || (ub.is_inf && ua.is_zero))   mul_res = QNAN;
    else if (ua.is_inf || ub.is_inf)                                    mul_res = {sx, POS_INF[30:0]};
    else if (ua.is_zero || ub.is_zero)                                  mul_res = {sx, 31'd0};
  end

  logic unused_bits;
  assign unused_bits = ^{prod[22:0], norm_dif[23]};

  logic [31:0] next_result;

  always_comb begin
    next_result = '0;
    case (op_sel)
      OP_ADD, OP_SUB: next_result = add_res;
      OP_MUL:         next_result = mul_res;
      default:        next_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) result <= next_result;
    end
  end

endmodule

// File: tb/tb_fp_add_mul_unit.sv
// Directed scoreboard bench for fp_add_mul_unit: expected values queued at issue,
// popped and compared one edge later.
module tb_fp_add_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic [31:0] result;
  logic        out_valid;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_exp;

  fp_add_mul_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op),
    .A(A), .B(B), .result(result), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] e;
    in_valid = 1'b1; op = o; A = a; B = b;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (sb_q.size() == 0) check({tag, "_queue"}, 32'd0, 32'd1);
    else begin
      e = sb_q.pop_front();
      check(tag, result, e);
      last_exp = e;
    end
  endtask

  task automatic idle(input string tag);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_hold"}, result, last_exp);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; op = 2'b00; A = '0; B = '0; last_exp = '0;
    #1;
    check("rst_result", result, 32'h0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    issue("add_1_2",    2'b00, 32'h3F800000, 32'h40000000, 32'h40400000);
    issue("sub_2_1",    2'b01, 32'h40000000, 32'h3F800000, 32'h3F800000);
    issue("sub_1_2",    2'b01, 32'h3F800000, 32'h40000000, 32'hBF800000);
    issue("sub_cancel", 2'b01, 32'h40400000, 32'h40400000, 32'h00000000);
    issue("mul_1_2",    2'b10, 32'h3F800000, 32'h40000000, 32'h40000000);
    issue("mul_3_mh",   2'b10, 32'h40400000, 32'hBF000000, 32'hBFC00000);
    idle("idle1");
    issue("mul_ovf",    2'b10, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000);
    issue("inf_m_inf",  2'b00, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
    issue("inf_x_0",    2'b10, 32'h7F800000, 32'h00000000, 32'h7FC00000);
    issue("mul_unf",    2'b10, 32'h00800000, 32'h00800000, 32'h00000000);
    issue("add_carry",  2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000);
    issue("sub_norm",   2'b01, 32'h3FC00000, 32'h3F800000, 32'h3F000000);
    issue("add_trunc",  2'b00, 32'h3F800000, 32'h33800000, 32'h3F800000);
    issue("add_ovf",    2'b00, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    issue("nan_in",     2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00000);
    issue("inf_add_f",  2'b00, 32'h7F800000, 32'h3F800000, 32'h7F800000);
    issue("ninf_mul",   2'b10, 32'hFF800000, 32'h40000000, 32'hFF800000);
    issue("zero_sub_x", 2'b01, 32'h00000000, 32'h3F800000, 32'hBF800000);
    issue("nz_p_pz",    2'b00, 32'h80000000, 32'h00000000, 32'h00000000);
    issue("sub_flush",  2'b00, 32'h00400000, 32'h3F800000, 32'h3F800000);
    issue("nz_mul",     2'b10, 32'h80000000, 32'h3F800000, 32'h80000000);
    issue("op_rsv",     2'b11, 32'h3F800000, 32'h40000000, 32'h00000000);
    issue("pre_rst",    2'b10, 32'h40400000, 32'h40000000, 32'h40C00000);
    idle("idle2");

    // Reset mid-stream with an op presented but not yet clocked.
    in_valid = 1'b1; op = 2'b00; A = 32'h3F800000; B = 32'h40000000;
    #2 reset = 1'b0;
    #1;
    check("async_rst_result", result, 32'h0);
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("rst_edge_result", result, 32'h0);
    check("rst_edge_valid", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_result", result, 32'h0);
    last_exp = 32'h0;

    issue("recover",    2'b00, 32'h3F800000, 32'h40000000, 32'h40400000);
    idle("idle3");
    check("queue_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
